// File: rtl/bcd_scan_display.sv
// ---------------------------------------------------------------------------
// bcd_scan_display
//   Captures a 16-bit unsigned magnitude, converts it to four BCD digits with
//   a sequential shift-add-3 (double-dabble) engine, one bit per clock, and
//   drives a multiplexed, active-low 4-digit 7-segment display.
//
//   Values above 9999 are shown as four dashes.
//
//   Optional leading-zero blanking is enabled by defining the macro
//   BCD_SCAN_DISPLAY_BLANK_EN. The default build shows all four digits.
//
// Parameters
//   REFRESH_DIV : clk cycles each digit is driven before the scan advances
//                 (2 .. 2^24-1).
//
// Ports
//   clk    in   1  : clock; all state changes on its rising edge
//   rst_n  in   1  : asynchronous active-low reset
//   value  in  16  : magnitude to display
//   load   in   1  : single-cycle capture request (ignored while busy)
//   dp_en  in   1  : sampled with load; lights the hundreds decimal point
//   busy   out  1  : high while a capture is being converted
//   c      out  7  : active-low segments, c[0:6] = a..g
//   d      out  4  : active-low digit anodes, d[0] = ones
//   dp     out  1  : active-low decimal point
// ---------------------------------------------------------------------------
module bcd_scan_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        dp_en,
  output logic        busy,
  output logic [0:6]  c,
  output logic [3:0]  d,
  output logic        dp
);

  localparam logic [23:0] PRESC_LAST = 24'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_DASH   = 7'b1111110;
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] shift_reg;   // remaining binary bits, MSB first
  logic [15:0] bcd_acc;     // partial BCD result
  logic [3:0]  iter;        // iterations already done
  logic        dp_pend;     // dp_en captured with the pending value
  logic        ovr_pend;    // overrange flag of the pending value

  logic [15:0] disp_bcd;    // digits currently on display
  logic        disp_dp;
  logic        disp_ovr;

  logic [23:0] presc;
  logic [1:0]  scan_idx;

  logic [15:0] bcd_next;
  logic [3:0]  cur_digit;
  logic        blank;
  logic [6:0]  seg_next;
  logic        dp_next;

  // One double-dabble step: correct every digit >= 5 by +3, then shift in_bit in.
  function automatic logic [15:0] dabble_step(input logic [15:0] bcd, input logic in_bit);
    logic [15:0] adj;
    adj = 16'd0;
    for (int k = 0; k < 4; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end else begin
        adj[4*k +: 4] = bcd[4*k +: 4];
      end
    end
    return {adj[14:0], in_bit};
  endfunction

  // Active-low segment pattern (a..g, a written first) for one BCD digit.
  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Next BCD accumulator value for the running conversion.
  always_comb begin
    bcd_next = dabble_step(bcd_acc, shift_reg[15]);
  end

  // Conversion FSM: capture, 16 shift-add-3 iterations, atomic display update.
  // The 16th iteration result is committed directly to the display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      shift_reg <= 16'd0;
      bcd_acc   <= 16'd0;
      iter      <= 4'd0;
      dp_pend   <= 1'b0;
      ovr_pend  <= 1'b0;
      disp_bcd  <= 16'd0;
      disp_dp   <= 1'b0;
      disp_ovr  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            shift_reg <= value;
            bcd_acc   <= 16'd0;
            iter      <= 4'd0;
            dp_pend   <= dp_en;
            ovr_pend  <= (value > 16'd9999);
            busy      <= 1'b1;
            state     <= ST_CONV;
          end else begin
            busy      <= 1'b0;
          end
        end
        ST_CONV: begin
          shift_reg <= {shift_reg[14:0], 1'b0};
          bcd_acc   <= bcd_next;
          iter      <= iter + 4'd1;
          if (iter == 4'd15) begin
            disp_bcd <= bcd_next;
            disp_dp  <= dp_pend;
            disp_ovr <= ovr_pend;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            busy     <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Segment/decimal-point selection for the digit the scanner is about to drive.
  always_comb begin
    cur_digit = 4'd0;
    blank     = 1'b0;
    case (scan_idx)
      2'd0:    cur_digit = disp_bcd[3:0];
      2'd1:    cur_digit = disp_bcd[7:4];
      2'd2:    cur_digit = disp_bcd[11:8];
      2'd3:    cur_digit = disp_bcd[15:12];
      default: cur_digit = 4'd0;
    endcase
`ifdef BCD_SCAN_DISPLAY_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero;
    // a fixed-point result keeps its tens and hundreds visible ("0.05").
    case (scan_idx)
      2'd3:    blank = (disp_bcd[15:12] == 4'd0);
      2'd2:    blank = (disp_bcd[15:8] == 8'd0) && !disp_dp;
      2'd1:    blank = (disp_bcd[15:4] == 12'd0) && !disp_dp;
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    if (disp_ovr) begin
      seg_next = SEG_DASH;
    end else if (blank) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = seg_of(cur_digit);
    end
    dp_next = !((scan_idx == 2'd2) && disp_dp && !disp_ovr);
  end

  // Refresh prescaler and scanner; outputs are reloaded together on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= 24'd0;
      scan_idx <= 2'd0;
      c        <= 7'b1111111;
      d        <= 4'b1111;
      dp       <= 1'b1;
    end else if (presc == PRESC_LAST) begin
      presc    <= 24'd0;
      scan_idx <= scan_idx + 2'd1;
      c        <= seg_next;
      d        <= ~(4'b0001 << scan_idx);
      dp       <= dp_next;
    end else begin
      presc    <= presc + 24'd1;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_display
//   Directed plus randomized bench for bcd_scan_display with REFRESH_DIV=4.
//   Expected display contents come from a decimal model (division by powers
//   of ten), not from the converter structure.
// ---------------------------------------------------------------------------
module tb_bcd_scan_display;

  localparam int unsigned DIV = 4;
`ifdef BCD_SCAN_DISPLAY_BLANK_EN
  localparam bit BLANK_MODE = 1'b1;
`else
  localparam bit BLANK_MODE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        dp_en;
  logic        busy;
  logic [0:6]  c;
  logic [3:0]  d;
  logic        dp;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [10];
  int         pw [4];

  bcd_scan_display #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .dp_en (dp_en),
    .busy  (busy),
    .c     (c),
    .d     (d),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected segment pattern of digit position i for a displayed value.
  function automatic logic [6:0] exp_c(input int v, input bit dpf, input int i);
    if (v > 9999) return 7'b1111110;
    if (BLANK_MODE && i > 0 && v < pw[i] && !(dpf && (i == 1 || i == 2)))
      return 7'b1111111;
    return seg_tab[(v / pw[i]) % 10];
  endfunction

  function automatic logic exp_dp(input int v, input bit dpf, input int i);
    return (v <= 9999 && dpf && i == 2) ? 1'b0 : 1'b1;
  endfunction

  // Pulse load for one cycle (caller is at a negedge); value is then scrambled.
  task automatic do_load(input int v, input bit dpf);
    value = 16'(v);
    dp_en = dpf;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    value = 16'($urandom);
    dp_en = 1'($urandom);
  endtask

  // Wait for busy to fall, checking the number of cycles it took.
  task automatic wait_done(input string tag, input int exp_cycles);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_cycles));
  endtask

  // Let a full scan round pass, then verify every strobed digit for 16 cycles.
  task automatic check_display(input string tag, input int v, input bit dpf);
    int idx;
    repeat (4 * DIV) @(negedge clk);
    for (int j = 0; j < 4 * DIV; j++) begin
      @(negedge clk);
      case (d)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        check({tag, "_d_onehot"}, 32'(d), 32'hE);
      end else begin
        check({tag, "_c"}, 32'(c), 32'(exp_c(v, dpf, idx)));
        check({tag, "_dp"}, 32'(dp), 32'(exp_dp(v, dpf, idx)));
      end
    end
  endtask

  task automatic convert(input string tag, input int v, input bit dpf);
    do_load(v, dpf);
    check({tag, "_busy_set"}, 32'(busy), 32'd1);
    wait_done(tag, 16);
    check_display(tag, v, dpf);
  endtask

  // Release reset at a negedge and verify the first scan update and cadence.
  task automatic release_and_scan(input string tag);
    rst_n = 1'b1;
    for (int k = 0; k < DIV - 1; k++) begin
      @(negedge clk);
      check({tag, "_pre_scan_d"}, 32'(d), 32'hF);
    end
    @(negedge clk);
    for (int j = 0; j < 4 * DIV; j++) begin
      if (j > 0) @(negedge clk);
      check({tag, "_scan_d"}, 32'(d), 32'(~(4'b0001 << (j / DIV)) & 4'hF));
      check({tag, "_scan_c"}, 32'(c), 32'(exp_c(0, 1'b0, j / DIV)));
      check({tag, "_scan_dp"}, 32'(dp), 32'd1);
    end
  endtask

  initial begin
    int v;
    bit f;
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    pw = '{1, 10, 100, 1000};
    rst_n = 1'b0;
    load  = 1'b0;
    value = 16'd0;
    dp_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_d", 32'(d), 32'hF);
    check("rst_c", 32'(c), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);

    // First scan exactly DIV cycles after release, then 1110/1101/1011/0111
    release_and_scan("init");
    check_display("zero", 0, 1'b0);

    // 1234, busy high for exactly 16 sampled cycles
    do_load(1234, 1'b0);
    for (int k = 0; k < 16; k++) begin
      check("b1234_busy_hi", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("b1234_busy_lo", 32'(busy), 32'd0);
    check_display("v1234", 1234, 1'b0);

    // 9999 with a second load during conversion that must be ignored
    do_load(9999, 1'b0);
    repeat (4) @(negedge clk);
    value = 16'd5;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_done("v9999", 11);
    check_display("v9999", 9999, 1'b0);

    // Overrange
    convert("v10000", 10000, 1'b1);
    convert("v65535", 65535, 1'b0);

    // Fixed-point, decimal point on hundreds
    convert("v125dp", 125, 1'b1);
    convert("v5dp", 5, 1'b1);
    convert("v7", 7, 1'b0);

    // Load in the cycle busy falls is accepted
    do_load(777, 1'b0);
    wait_done("b2b_a", 16);
    do_load(42, 1'b1);
    check("b2b_busy_set", 32'(busy), 32'd1);
    wait_done("b2b_b", 16);
    check_display("b2b", 42, 1'b1);

    // Randomized values around the 9999 boundary
    for (int r = 0; r < 8; r++) begin
      v = (r < 2) ? 9999 + r : int'($urandom_range(0, 12000));
      f = 1'($urandom);
      convert("rand", v, f);
    end

    // Reset in the middle of a conversion of 4321
    do_load(4321, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_d", 32'(d), 32'hF);
    check("abort_c", 32'(c), 32'h7F);
    check("abort_dp", 32'(dp), 32'd1);
    @(negedge clk);
    release_and_scan("abort");
    repeat (20) @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    check_display("abort_zero", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles each digit is driven before advancing (legal range 2 to 2^24-1).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port value  input  16  unsigned result magnitude to display.
REQ-005 The block SHALL have port load  input  1  single-cycle request to capture value.
REQ-006 The block SHALL have port dp_en  input  1  sampled with load; lights the decimal point of digit 2 (hundreds) for fixed-point results.
REQ-007 The block SHALL have port busy  output  1  high while a capture is being converted.
REQ-008 The block SHALL have port c  output  7 (bits [0:6]=a..g)  active-low segment drive.
REQ-009 The block SHALL have port d  output  4  active-low digit anodes, d[0]=ones.
REQ-010 The block SHALL have port dp  output  1  active-low decimal point.

Function
REQ-011 A load SHALL be accepted only on a cycle where busy=0; load while busy=1 SHALL be ignored with no side effect.
REQ-012 On acceptance the block SHALL latch value and dp_en, assert busy the next cycle, and run a sequential shift-add-3 (double-dabble) conversion of one bit per cycle for 16 cycles.
REQ-013 On the cycle after the 16th iteration the four BCD digits, the dp_en copy and the overrange flag SHALL update the display registers atomically, and busy SHALL fall in that same cycle (load-to-display latency 17 cycles).
REQ-014 A load asserted on the cycle busy falls SHALL be accepted.
REQ-015 Until a new conversion completes, the previously displayed digits SHALL remain on the display unchanged.
REQ-016 value > 9999 SHALL set overrange; while overrange is displayed, all four digits SHALL show a dash (c=1111110) and dp SHALL be 1.
REQ-017 Digit encodings SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-018 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap the scan index SHALL advance 0->1->2->3->0.
REQ-019 Scan index i SHALL drive d with only bit i low (1110, 1101, 1011, 0111), c with digit i, and dp low only when i=2 and the latched dp_en=1.
REQ-020 c, d and dp SHALL be registered outputs that change in the same cycle as each other.
REQ-021 Scanning SHALL run continuously, independent of busy and load.

Reset
REQ-022 While rst_n=0: busy=0, d=1111, c=1111111, dp=1, prescaler=0, scan index=0, display digits=0, dp_en copy=0, overrange=0.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion; after release the display SHALL show 0000 and the first scan update SHALL occur REFRESH_DIV cycles after release.

Configuration
REQ-024 Macro BCD_SCAN_DISPLAY_BLANK_EN SHALL control leading-zero blanking.
REQ-025 With BCD_SCAN_DISPLAY_BLANK_EN defined, each leading zero digit above the ones digit SHALL be blank (c=1111111, d still strobed); when the latched dp_en=1, the hundreds and tens digits SHALL never be blanked; the ones digit SHALL always show.
REQ-026 Without BCD_SCAN_DISPLAY_BLANK_EN, all four digits SHALL always be shown, including leading zeros.

Verification (REFRESH_DIV=4 for the bench)
REQ-027 Reset release, no load -> d cycles 1110,1101,1011,0111 every 4 clocks; c=0000001 on every digit; dp=1.
REQ-028 load with value=1234, dp_en=0 -> busy high for cycles 1..16; display updates on cycle 17; digits read 4,3,2,1.
REQ-029 load with value=0x270F (9999) followed by a second load with value=5 on cycle 5 -> the second load is ignored; display shows 9999.
REQ-030 load with value=10000 -> all digits show dash (1111110), dp=1.
REQ-031 load with value=125, dp_en=1 -> dp=0 only while d=1011; with the blank macro defined, the display reads " 125" (thousands blank); without it, "0125".
REQ-032 rst_n pulsed low at cycle 8 of converting 4321 -> busy=0 immediately; display 0000; no later update from the aborted conversion.
